// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the program-counter generator: PC offer handshake,
// redirect/trap sources and halt/resume control.
interface pc_gen_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  if_ready;
   logic                  redirect_req;
   logic [ADDR_WIDTH-1:0] redirect_pc;
   logic                  trap_req;
   logic [ADDR_WIDTH-1:0] trap_vec;
   logic                  halt_req;
   logic                  resume_req;
   logic [ADDR_WIDTH-1:0] pc_current;
   logic                  pc_valid;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic                  misalign_err;
   logic                  halted;

   modport master (
      input  if_ready, redirect_req, redirect_pc, trap_req, trap_vec, halt_req, resume_req,
      output pc_current, pc_valid, pc_next, misalign_err, halted
   );

   modport slave (
      output if_ready, redirect_req, redirect_pc, trap_req, trap_vec, halt_req, resume_req,
      input  pc_current, pc_valid, pc_next, misalign_err, halted
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: holds the fetch PC, offers it over valid/ready and
// picks the next PC by priority trap > redirect > sequential step > hold.
module pc_gen #(
   parameter int                    ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    STEP         = 4,
   parameter int                    ALIGN_BITS   = 2
) (
   input  logic      clk,
   input  logic      rst,
   pc_gen_if.master  bus
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   localparam logic [ADDR_WIDTH-1:0] STEP_W     = ADDR_WIDTH'(STEP);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

   state_t                state_q;
   state_t                state_d;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic                  valid_q;
   logic                  halted_q;
   logic                  err_q;
   logic                  err_d;
   logic                  misaligned;

   assign misaligned = |(bus.redirect_pc & ALIGN_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= BOOT;
         pc_q     <= RESET_VECTOR;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= (state_d == RUN);
         halted_q <= (state_d == HALT);
         err_q    <= err_d;
      end
   end

   // A trap wakes the core from HALT unless halt is asserted alongside it.
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (bus.halt_req) state_d = HALT;
         HALT:    if ((bus.trap_req || bus.resume_req) && !bus.halt_req) state_d = RUN;
         default: state_d = BOOT;
      endcase
   end

   // A misaligned redirect falls back to the trap vector and flags the error.
   always_comb begin
      pc_d  = pc_q;
      err_d = 1'b0;
      if (state_q != BOOT) begin
         if (bus.trap_req) begin
            pc_d = bus.trap_vec;
         end else if (bus.redirect_req) begin
            if (misaligned) begin
               pc_d  = bus.trap_vec;
               err_d = 1'b1;
            end else begin
               pc_d = bus.redirect_pc;
            end
         end else if (state_q == RUN && valid_q && bus.if_ready) begin
            pc_d = pc_q + STEP_W;
         end
      end
   end

   assign bus.pc_current   = pc_q;
   assign bus.pc_valid     = valid_q;
   assign bus.pc_next      = pc_d;
   assign bus.misalign_err = err_q;
   assign bus.halted       = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected post-edge outputs are queued as each
// cycle's stimulus is driven and popped once the clock edge has produced them.
module tb_pc_gen;

   typedef struct {
      logic [31:0] pc;
      logic        valid;
      logic        halted;
      logic        err;
   } exp_t;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;
   exp_t sb[$];

   pc_gen_if #(.ADDR_WIDTH(32)) bus ();

   pc_gen #(
      .ADDR_WIDTH(32),
      .RESET_VECTOR(32'h0000_0000),
      .STEP(4),
      .ALIGN_BITS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus driven at the falling edge; pc_next must already predict the next PC.
   task automatic applyStimulus(
      input logic        r,
      input logic        rdy,
      input logic        rreq,
      input logic [31:0] rpc,
      input logic        treq,
      input logic [31:0] tvec,
      input logic        hreq,
      input logic        resreq,
      input logic [31:0] e_pc,
      input logic        e_valid,
      input logic        e_halted,
      input logic        e_err
   );
      exp_t e;
      @(negedge clk);
      rst              = r;
      bus.if_ready     = rdy;
      bus.redirect_req = rreq;
      bus.redirect_pc  = rpc;
      bus.trap_req     = treq;
      bus.trap_vec     = tvec;
      bus.halt_req     = hreq;
      bus.resume_req   = resreq;
      e.pc     = e_pc;
      e.valid  = e_valid;
      e.halted = e_halted;
      e.err    = e_err;
      sb.push_back(e);
      #1;
      if (!r) checkOutput("pc_next", bus.pc_next, e_pc);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("pc_current", bus.pc_current, e.pc);
         checkOutput("pc_valid", {31'd0, bus.pc_valid}, {31'd0, e.valid});
         checkOutput("halted", {31'd0, bus.halted}, {31'd0, e.halted});
         checkOutput("misalign_err", {31'd0, bus.misalign_err}, {31'd0, e.err});
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst              = 1'b1;
      bus.if_ready     = 1'b0;
      bus.redirect_req = 1'b0;
      bus.redirect_pc  = '0;
      bus.trap_req     = 1'b0;
      bus.trap_vec     = '0;
      bus.halt_req     = 1'b0;
      bus.resume_req   = 1'b0;

      //            rst  rdy  rreq rpc           treq tvec          halt res  pc            v    h    err
      applyStimulus(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b0);
      applyStimulus(1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0000,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0004,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0008,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_000C,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0010,1'b1,1'b0,1'b0);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0,1'b0,1'b0,32'h0,     1'b0,32'h0,        1'b0,1'b0,32'h0000_0010,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,1'b0,32'h0000_0014,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b1,32'h200,      1'b1,32'h80,       1'b0,1'b0,32'h0000_0080,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b1,32'h202,      1'b0,32'h100,      1'b0,1'b0,32'h0000_0100,1'b1,1'b0,1'b1);
      applyStimulus(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0100,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b1,32'h40,       1'b0,32'h100,      1'b0,1'b0,32'h0000_0040,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b1,1'b0,32'h0000_0044,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0044,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b1,32'h0000_0044,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0048,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h100,      1'b0,1'b0,32'hFFFF_FFFC,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0000,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0004,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0004,1'b1,1'b0,1'b0);
      applyStimulus(1'b1,1'b0,1'b0,32'h0,        1'b0,32'h100,      1'b0,1'b0,32'h0000_0000,1'b0,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h80,       1'b1,1'b0,32'h0000_0000,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b0,1'b0,32'h0,        1'b0,32'h80,       1'b1,1'b0,32'h0000_0000,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b0,1'b1,32'h300,      1'b0,32'h80,       1'b0,1'b0,32'h0000_0300,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b0,1'b0,32'h0,        1'b1,32'h80,       1'b0,1'b0,32'h0000_0080,1'b1,1'b0,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b1,32'h90,       1'b1,1'b0,32'h0000_0090,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h90,       1'b1,1'b1,32'h0000_0090,1'b0,1'b1,1'b0);
      applyStimulus(1'b0,1'b1,1'b0,32'h0,        1'b0,32'h90,       1'b0,1'b1,32'h0000_0090,1'b1,1'b0,1'b0);

      repeat (2) @(posedge clk);
      #2;
      checkOutput("sb_drain", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
